// File: rtl/bw_pwm_pkg.sv
// Shared register map and bit positions for the GPMC-attached PWM bank.
// Addresses are word addresses on the bridge's decoded bus.
package bw_pwm_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_PRESCALE = 1;
  localparam int unsigned REG_PERIOD   = 2;
  localparam int unsigned REG_STATUS   = 3;
  localparam int unsigned REG_DUTY0    = 4;

  localparam int unsigned CTRL_EN_BIT     = 15;
  localparam int unsigned STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty register and registered compare output.
// The active duty only changes at a period wrap, or continuously while the bank is stopped.
module pwm_channel
  import bw_pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cnt,
  input  logic                  wrap,
  input  logic                  load_now,
  input  logic                  enable,
  input  logic                  duty_we,
  input  logic [DATA_WIDTH-1:0] duty_wdata,
  output logic [DATA_WIDTH-1:0] duty_shadow,
  output logic                  pwm
);

  logic [DATA_WIDTH-1:0] duty_act;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_act    <= '0;
      pwm         <= 1'b0;
    end else begin
      if (duty_we) begin
        duty_shadow <= duty_wdata;
      end
      if (load_now || wrap) begin
        duty_act <= duty_shadow;
      end
      pwm <= enable && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/gpmc_pwm_bank.sv
// Register-mapped PWM bank behind the GPMC bridge: bus decode, shared prescaler and
// period counter, and NUM_CH channels with glitch-free double-buffered period/duty.
module gpmc_pwm_bank
  import bw_pwm_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_we,
  input  logic                  bus_re,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_rvalid,
  output logic [NUM_CH-1:0]     pwm_out
);

  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] prescale_q;
  logic [DATA_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0] period_act;
  logic [DATA_WIDTH-1:0] pre_cnt;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  status_wrap;

  logic en;
  logic load_now;
  logic tick;
  logic wrap;

  logic wr_ctrl;
  logic wr_prescale;
  logic wr_period;
  logic wr_status;

  logic [NUM_CH-1:0]     duty_we;
  logic [DATA_WIDTH-1:0] duty_shadow [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign en       = ctrl_q[CTRL_EN_BIT];
  assign load_now = !en;
  assign tick     = en && (pre_cnt == prescale_q);
  assign wrap     = tick && (cnt == period_act);

  assign wr_ctrl     = bus_we && (bus_addr == ADDR_WIDTH'(REG_CTRL));
  assign wr_prescale = bus_we && (bus_addr == ADDR_WIDTH'(REG_PRESCALE));
  assign wr_period   = bus_we && (bus_addr == ADDR_WIDTH'(REG_PERIOD));
  assign wr_status   = bus_we && (bus_addr == ADDR_WIDTH'(REG_STATUS));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    duty_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_we[i] = bus_we && (bus_addr == ADDR_WIDTH'(REG_DUTY0 + i));
    end
  end

  // NOTE: all registers, including per-channel duty storage, are reset so reads return 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      period_q   <= '0;
    end else begin
      if (wr_ctrl)     ctrl_q     <= bus_wdata;
      if (wr_prescale) prescale_q <= bus_wdata;
      if (wr_period)   period_q   <= bus_wdata;
    end
  end

  // A shrunken PRESCALE below pre_cnt lets pre_cnt run up and roll over rather than jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (!en) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      cnt     <= wrap ? '0 : cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Set wins over a simultaneous write-1-to-clear so no wrap event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act  <= '0;
      status_wrap <= 1'b0;
    end else begin
      if (load_now || wrap) begin
        period_act <= period_q;
      end
      if (wrap) begin
        status_wrap <= 1'b1;
      end else if (wr_status && bus_wdata[STATUS_WRAP_BIT]) begin
        status_wrap <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus_addr == ADDR_WIDTH'(REG_CTRL)) begin
      rd_mux = ctrl_q;
    end else if (bus_addr == ADDR_WIDTH'(REG_PRESCALE)) begin
      rd_mux = prescale_q;
    end else if (bus_addr == ADDR_WIDTH'(REG_PERIOD)) begin
      rd_mux = period_q;
    end else if (bus_addr == ADDR_WIDTH'(REG_STATUS)) begin
      rd_mux[STATUS_WRAP_BIT] = status_wrap;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_addr == ADDR_WIDTH'(REG_DUTY0 + i)) begin
        rd_mux = duty_shadow[i];
      end
    end
  end

  // Read data is sampled before this edge's write lands, so a same-cycle read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re) begin
        bus_rdata <= rd_mux;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .wrap       (wrap),
      .load_now   (load_now),
      .enable     (en && ctrl_q[gi]),
      .duty_we    (duty_we[gi]),
      .duty_wdata (bus_wdata),
      .duty_shadow(duty_shadow[gi]),
      .pwm        (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_gpmc_pwm_bank.sv
// Self-checking bench for gpmc_pwm_bank: scoreboard queues for read data and per-cycle
// PWM output, scenario tasks run in sequence from one initial block.
module tb_gpmc_pwm_bank;
  import bw_pwm_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NC = 4;

  localparam logic [AW-1:0] A_CTRL     = AW'(REG_CTRL);
  localparam logic [AW-1:0] A_PRESCALE = AW'(REG_PRESCALE);
  localparam logic [AW-1:0] A_PERIOD   = AW'(REG_PERIOD);
  localparam logic [AW-1:0] A_STATUS   = AW'(REG_STATUS);
  localparam logic [AW-1:0] A_DUTY0    = AW'(REG_DUTY0);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bus_we = 1'b0;
  logic          bus_re = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic [DW-1:0] bus_rdata;
  logic          bus_rvalid;
  logic [NC-1:0] pwm_out;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int e0 = 0;

  logic [DW-1:0] rd_q [$];
  logic [NC-1:0] pwm_q [$];

  gpmc_pwm_bank #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_CH    (NC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .pwm_out   (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Bus primitives: called at a negedge, the access is captured by the next posedge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    logic [DW-1:0] e;
    bus_re   = 1'b1;
    bus_addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    bus_re = 1'b0;
    n_cmp++;
    if (bus_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL %s rvalid: got %b want 1", name, bus_rvalid);
    end
    e = rd_q.pop_front();
    n_cmp++;
    if (bus_rdata !== e) begin
      n_err++;
      $display("FAIL %s rdata: got 0x%04h want 0x%04h", name, bus_rdata, e);
    end
  endtask

  // Advance so the next bus access is captured on relative edge t.
  task automatic go(input int t);
    if (edge_cnt > t - 1) begin
      n_cmp++;
      n_err++;
      $display("FAIL schedule: at edge %0d, target edge %0d already passed", edge_cnt, t);
    end
    while (edge_cnt < t - 1) @(negedge clk);
  endtask

  task automatic check_pwm(input int n, input string name);
    logic [NC-1:0] e;
    repeat (n) begin
      @(negedge clk);
      n_cmp++;
      if (pwm_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: scoreboard empty at edge %0d, got %b", name, edge_cnt, pwm_out);
      end else begin
        e = pwm_q.pop_front();
        if (pwm_out !== e) begin
          n_err++;
          $display("FAIL %s: edge %0d pwm_out got %b want %b", name, edge_cnt - e0, pwm_out, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (pwm_out !== '0 || bus_rvalid !== 1'b0 || bus_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_state: pwm %b rvalid %b rdata 0x%04h want 0/0/0", pwm_out, bus_rvalid,
               bus_rdata);
    end
    wr(A_PERIOD, 16'd4);
    wr(A_DUTY0, 16'd2);
    wr(A_CTRL, 16'h8001);
    for (int i = 0; i < 30 && pwm_out[0] !== 1'b1; i++) @(negedge clk);
    n_cmp++;
    if (pwm_out[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prerun: pwm_out[0] got %b want 1 before reset", pwm_out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pwm_out !== '0) begin
      n_err++;
      $display("FAIL reset_async: pwm_out got %b want 0000", pwm_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(A_CTRL, 16'h0000, "reset_ctrl");
    rd(A_PERIOD, 16'h0000, "reset_period");
    rd(A_DUTY0, 16'h0000, "reset_duty0");
    for (int i = 0; i < 12; i++) pwm_q.push_back('0);
    check_pwm(12, "reset_idle");
  endtask

  task automatic test_basic();
    wr(A_PRESCALE, 16'd0);
    wr(A_PERIOD, 16'd9);
    wr(A_DUTY0, 16'd3);
    wr(A_CTRL, 16'h8001);
    e0 = edge_cnt;
    for (int k = 0; k < 20; k++) pwm_q.push_back(((k % 10) < 3) ? 4'b0001 : 4'b0000);
    check_pwm(20, "basic");
  endtask

  task automatic test_duty_update();
    int w;
    int bnd;
    w = edge_cnt - e0 + 1;
    wr(A_DUTY0, 16'd7);
    bnd = (w / 10 + 1) * 10;
    for (int k = w; k < w + 29; k++) begin
      pwm_q.push_back(((k % 10) < ((k >= bnd) ? 7 : 3)) ? 4'b0001 : 4'b0000);
    end
    check_pwm(29, "duty_update");
  endtask

  task automatic test_const();
    wr(A_CTRL, 16'h0001);
    for (int i = 0; i < 3; i++) pwm_q.push_back('0);
    check_pwm(3, "stop_low");
    wr(AW'(REG_DUTY0 + 1), 16'h0000);
    wr(AW'(REG_DUTY0 + 2), 16'hFFFF);
    wr(A_CTRL, 16'h8006);
    e0 = edge_cnt;
    for (int i = 0; i < 20; i++) pwm_q.push_back(4'b0100);
    check_pwm(20, "const");
    rd(A_PERIOD, 16'd9, "period_shadow");
  endtask

  task automatic test_unmapped();
    rd(AW'(4'hF), 16'h0000, "unmapped_rd");
    wr(AW'(4'hF), 16'h1234);
    wr(AW'(4'h8), 16'h5555);
    for (int i = 0; i < 10; i++) pwm_q.push_back(4'b0100);
    check_pwm(10, "unmapped_pwm");
    rd(AW'(4'h8), 16'h0000, "unmapped_rd8");
    rd(A_CTRL, 16'h8006, "keep_ctrl");
    rd(A_PRESCALE, 16'h0000, "keep_prescale");
    rd(A_PERIOD, 16'd9, "keep_period");
    rd(A_DUTY0, 16'd7, "keep_duty0");
    rd(AW'(REG_DUTY0 + 3), 16'h0000, "keep_duty3");
    rd(A_STATUS, 16'h0001, "status_running");
  endtask

  task automatic test_status();
    wr(A_CTRL, 16'h0000);
    wr(A_PRESCALE, 16'd3);
    wr(A_PERIOD, 16'd1);
    wr(A_STATUS, 16'h0001);
    wr(A_CTRL, 16'h8000);
    e0 = edge_cnt;
    // Wraps land on relative edges 8, 16, 24, ...
    rd(A_STATUS, 16'h0000, "status_clear_start");
    go(e0 + 10);
    rd(A_STATUS, 16'h0001, "status_first_wrap");
    go(e0 + 16);
    wr(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0001, "status_set_wins");
    wr(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0000, "status_w1c");
    go(e0 + 25);
    rd(A_STATUS, 16'h0001, "status_period8");
    wr(A_STATUS, 16'h0000);
    rd(A_STATUS, 16'h0001, "status_w0_noop");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [6];
    logic [DW-1:0] exps  [6];
    logic [DW-1:0] e;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    bus_addr  = A_PRESCALE;
    bus_wdata = 16'd5;
    rd_q.push_back(16'd3);
    @(negedge clk);
    bus_we = 1'b0;
    bus_re = 1'b0;
    e = rd_q.pop_front();
    n_cmp++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== e) begin
      n_err++;
      $display("FAIL rd_wr_same: rvalid %b rdata 0x%04h want 1 0x%04h", bus_rvalid, bus_rdata, e);
    end
    addrs = '{A_PRESCALE, A_PERIOD, A_DUTY0, AW'(REG_DUTY0 + 1), AW'(REG_DUTY0 + 2), A_CTRL};
    exps  = '{16'd5, 16'd1, 16'd7, 16'h0000, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 6; i++) begin
      bus_re   = 1'b1;
      bus_addr = addrs[i];
      rd_q.push_back(exps[i]);
      @(negedge clk);
      e = rd_q.pop_front();
      n_cmp++;
      if (bus_rvalid !== 1'b1 || bus_rdata !== e) begin
        n_err++;
        $display("FAIL burst_%0d: rvalid %b rdata 0x%04h want 1 0x%04h", i, bus_rvalid, bus_rdata,
                 e);
      end
    end
    bus_re = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 16'h8000) begin
      n_err++;
      $display("FAIL rdata_hold: rvalid %b rdata 0x%04h want 0 0x8000", bus_rvalid, bus_rdata);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_duty_update();
    test_const();
    test_unmapped();
    test_status();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
